// File: rtl/norm_col_feeder_pkg.sv
// Shared constants and FSM encoding for the norm column-stream feeder.
package norm_col_feeder_pkg;
    localparam int DWIDTH             = 8;
    localparam int DESIGN_SIZE        = 16;
    localparam int AWIDTH             = 10;
    localparam int ADDR_STRIDE_WIDTH  = 16;
    localparam int MASK_WIDTH         = 16;
    localparam int MEM_ACCESS_LATENCY = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_WAIT_DONE,
        S_DONE
    } feeder_state_e;
endpackage

// File: rtl/norm_addr_gen.sv
// Strided address accumulator with column counter; flags the final column.
module norm_addr_gen #(
    parameter int AWIDTH = 10,
    parameter int SWIDTH = 16,
    parameter int COUNT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [AWIDTH-1:0] base,
    input  logic [SWIDTH-1:0] stride,
    output logic [AWIDTH-1:0] addr,
    output logic              last
);
    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [AWIDTH-1:0] addr_q;
    logic [SWIDTH-1:0] stride_q;
    logic [CW-1:0]     cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            stride_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            addr_q   <= base;
            stride_q <= stride;
            cnt_q    <= '0;
        end else if (step) begin
            // Truncating add gives the mod 2^AWIDTH wrap and drops high stride bits.
            addr_q <= AWIDTH'(addr_q + stride_q);
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign addr = addr_q;
    assign last = (cnt_q == CW'(COUNT - 1));
endmodule

// File: rtl/norm_col_feeder.sv
// Streams DESIGN_SIZE strided RAM columns gap-free into norm, then waits for done_norm.
module norm_col_feeder #(
    parameter int DWIDTH            = norm_col_feeder_pkg::DWIDTH,
    parameter int DESIGN_SIZE       = norm_col_feeder_pkg::DESIGN_SIZE,
    parameter int AWIDTH            = norm_col_feeder_pkg::AWIDTH,
    parameter int ADDR_STRIDE_WIDTH = norm_col_feeder_pkg::ADDR_STRIDE_WIDTH,
    parameter int MASK_WIDTH        = norm_col_feeder_pkg::MASK_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [AWIDTH-1:0]             base_addr,
    input  logic [ADDR_STRIDE_WIDTH-1:0]  addr_stride,
    input  logic [MASK_WIDTH-1:0]         mask_in,
    output logic                          ram_en,
    output logic [AWIDTH-1:0]             ram_addr,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] ram_rdata,
    output logic                          in_data_available,
    output logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
    output logic [MASK_WIDTH-1:0]         validity_mask,
    input  logic                          done_norm,
    output logic                          busy,
    output logic                          done
);
    import norm_col_feeder_pkg::*;

    feeder_state_e         state_q, state_d;
    logic [MASK_WIDTH-1:0] mask_q;
    logic                  avail_q;
    logic                  load, step, last;
    logic [AWIDTH-1:0]     gen_addr;

    assign load = (state_q == S_IDLE) && start;
    assign step = (state_q == S_READ);

    norm_addr_gen #(
        .AWIDTH (AWIDTH),
        .SWIDTH (ADDR_STRIDE_WIDTH),
        .COUNT  (DESIGN_SIZE)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .base   (base_addr),
        .stride (addr_stride),
        .addr   (gen_addr),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            avail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            avail_q <= ram_en;
            if (load)
                mask_q <= mask_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_READ;
            S_READ:      if (last) state_d = S_LAST;
            S_LAST:      state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (done_norm) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    assign ram_en            = (state_q == S_READ);
    assign ram_addr          = ram_en ? gen_addr : '0;
    // Read data lands one cycle after the enable, so availability trails ram_en.
    assign in_data_available = avail_q;
    assign inp_data          = avail_q ? ram_rdata : '0;
    assign validity_mask     = mask_q;
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
endmodule

// File: tb/tb_norm_col_feeder.sv
// Directed bench for norm_col_feeder with a behavioural 1-cycle-latency RAM.
module tb_norm_col_feeder;
    localparam int DW = 128;
    localparam int NC = 40;

    logic          clk = 1'b0;
    logic          reset, start, done_norm;
    logic [9:0]    base_addr;
    logic [15:0]   addr_stride, mask_in;
    logic          ram_en, in_data_available, busy, done;
    logic [9:0]    ram_addr;
    logic [DW-1:0] ram_rdata, inp_data;
    logic [15:0]   validity_mask;

    int tests = 0;
    int failed = 0;

    int         dn_cycle = -1, start2_cycle = -1, rst_cycle = -1;
    bit         dn_tied = 1'b0;
    logic [9:0] base2 = 10'd100;

    logic          ob_en    [0:NC];
    logic [9:0]    ob_addr  [0:NC];
    logic          ob_avail [0:NC];
    logic [DW-1:0] ob_data  [0:NC];
    logic [15:0]   ob_mask  [0:NC];
    logic          ob_busy  [0:NC];
    logic          ob_done  [0:NC];

    norm_col_feeder dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_addr         (base_addr),
        .addr_stride       (addr_stride),
        .mask_in           (mask_in),
        .ram_en            (ram_en),
        .ram_addr          (ram_addr),
        .ram_rdata         (ram_rdata),
        .in_data_available (in_data_available),
        .inp_data          (inp_data),
        .validity_mask     (validity_mask),
        .done_norm         (done_norm),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        rep = {16{b}};
    endfunction

    function automatic logic [9:0] exp_addr(input int b, input int s, input int k);
        int t;
        t = (b + k * s) % 1024;
        return t[9:0];
    endfunction

    // RAM[a] = a[7:0] in every byte; garbage when not enabled so ungated data shows.
    always @(posedge clk)
        ram_rdata <= ram_en ? rep(ram_addr[7:0]) : {16{8'hA5}};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [9:0] b, input logic [15:0] s, input logic [15:0] m, input int n);
        base_addr = b; addr_stride = s; mask_in = m; start = 1'b1;
        tick();
        start = 1'b0; base_addr = 10'h3FF; addr_stride = 16'h7; mask_in = 16'h5A5A;
        for (int c = 1; c <= n; c++) begin
            ob_en[c] = ram_en; ob_addr[c] = ram_addr; ob_avail[c] = in_data_available;
            ob_data[c] = inp_data; ob_mask[c] = validity_mask; ob_busy[c] = busy; ob_done[c] = done;
            done_norm = dn_tied || (c == dn_cycle);
            start = (c == start2_cycle);
            if (start) begin base_addr = base2; mask_in = 16'h1234; end
            reset = (c == rst_cycle);
            tick();
        end
        start = 1'b0; reset = 1'b0; done_norm = dn_tied;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; done_norm = 1'b0;
        base_addr = 10'd9; addr_stride = 16'd1; mask_in = 16'hFFFF;
        tick(); tick();
        reset = 1'b0; start = 1'b0;
        tests++;
        if ({ram_en, ram_addr, in_data_available, inp_data, validity_mask, busy, done} !== '0) begin
            failed++;
            $display("FAIL reset_outputs en=%b addr=%0d avail=%b data=%h mask=%h busy=%b done=%b required all 0",
                     ram_en, ram_addr, in_data_available, inp_data, validity_mask, busy, done);
        end
    endtask

    task automatic test_basic();
        dn_cycle = 20;
        run(10'd0, 16'd1, 16'hFFFF, 24);
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (ob_en[k+1] !== 1'b1 || ob_addr[k+1] !== 10'(k)) begin
                failed++;
                $display("FAIL basic_addr k=%0d en=%b addr=%0d required en=1 addr=%0d", k, ob_en[k+1], ob_addr[k+1], k);
            end
            tests++;
            if (ob_avail[k+2] !== 1'b1 || ob_data[k+2] !== rep(8'(k))) begin
                failed++;
                $display("FAIL basic_data k=%0d avail=%b data=%h required avail=1 data=%h", k, ob_avail[k+2], ob_data[k+2], rep(8'(k)));
            end
        end
        tests++;
        if (ob_avail[1] !== 1'b0 || ob_data[1] !== '0 || ob_avail[18] !== 1'b0 || ob_data[18] !== '0) begin
            failed++;
            $display("FAIL basic_edges avail1=%b data1=%h avail18=%b data18=%h required 0", ob_avail[1], ob_data[1], ob_avail[18], ob_data[18]);
        end
        tests++;
        if (ob_en[17] !== 1'b0 || ob_addr[17] !== 10'd0) begin
            failed++;
            $display("FAIL basic_last_en en=%b addr=%0d required 0", ob_en[17], ob_addr[17]);
        end
        for (int c = 1; c <= 24; c++) begin
            tests++;
            if (ob_done[c] !== (c == 21) || ob_busy[c] !== (c <= 21)) begin
                failed++;
                $display("FAIL basic_done c=%0d done=%b busy=%b required done=%b busy=%b", c, ob_done[c], ob_busy[c], c == 21, c <= 21);
            end
        end
        tests++;
        if (ob_mask[1] !== 16'hFFFF) begin
            failed++;
            $display("FAIL basic_mask got=%h required=ffff", ob_mask[1]);
        end
        dn_cycle = -1;
    endtask

    task automatic test_stride_wrap();
        dn_cycle = 20;
        run(10'd1020, 16'd3, 16'hFFFF, 24);
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (ob_addr[k+1] !== exp_addr(1020, 3, k) || ob_data[k+2] !== rep(exp_addr(1020, 3, k)[7:0])) begin
                failed++;
                $display("FAIL wrap k=%0d addr=%0d data=%h required addr=%0d data=%h", k, ob_addr[k+1], ob_data[k+2],
                         exp_addr(1020, 3, k), rep(exp_addr(1020, 3, k)[7:0]));
            end
        end
        dn_cycle = -1;
    endtask

    task automatic test_norm_disabled();
        dn_tied = 1'b1; done_norm = 1'b1;
        run(10'd50, 16'd2, 16'hFFFF, 22);
        for (int c = 1; c <= 22; c++) begin
            tests++;
            if (ob_done[c] !== (c == 19) || ob_busy[c] !== (c <= 19)) begin
                failed++;
                $display("FAIL disabled_done c=%0d done=%b busy=%b required done=%b busy=%b", c, ob_done[c], ob_busy[c], c == 19, c <= 19);
            end
        end
        dn_tied = 1'b0; done_norm = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int ndone;
        dn_cycle = 20; start2_cycle = 5;
        run(10'd16, 16'd2, 16'hA5A5, 24);
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (ob_addr[k+1] !== exp_addr(16, 2, k)) begin
                failed++;
                $display("FAIL busy_start_addr k=%0d addr=%0d required %0d", k, ob_addr[k+1], exp_addr(16, 2, k));
            end
        end
        ndone = 0;
        for (int c = 1; c <= 24; c++) begin
            if (ob_done[c] === 1'b1) ndone++;
            tests++;
            if (ob_mask[c] !== 16'hA5A5) begin
                failed++;
                $display("FAIL busy_start_mask c=%0d got=%h required=a5a5", c, ob_mask[c]);
            end
        end
        tests++;
        if (ndone != 1 || ob_done[21] !== 1'b1) begin
            failed++;
            $display("FAIL busy_start_done count=%0d done21=%b required count=1 done21=1", ndone, ob_done[21]);
        end
        dn_cycle = -1; start2_cycle = -1;
    endtask

    task automatic test_reset_mid();
        int navail;
        rst_cycle = 8;
        run(10'd0, 16'd1, 16'hFFFF, 12);
        rst_cycle = -1;
        tests++;
        if ({ob_en[9], ob_addr[9], ob_avail[9], ob_data[9], ob_mask[9], ob_busy[9], ob_done[9]} !== '0) begin
            failed++;
            $display("FAIL reset_mid en=%b addr=%0d avail=%b data=%h mask=%h busy=%b done=%b required all 0",
                     ob_en[9], ob_addr[9], ob_avail[9], ob_data[9], ob_mask[9], ob_busy[9], ob_done[9]);
        end
        tests++;
        if (ob_busy[12] !== 1'b0 || ob_en[12] !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_idle busy=%b en=%b required 0", ob_busy[12], ob_en[12]);
        end
        dn_cycle = 20;
        run(10'd5, 16'd1, 16'hFFFF, 24);
        navail = 0;
        for (int c = 1; c <= 24; c++)
            if (ob_avail[c] === 1'b1) navail++;
        tests++;
        if (navail != 16 || ob_done[21] !== 1'b1 || ob_data[17] !== rep(8'd20)) begin
            failed++;
            $display("FAIL reset_mid_restart avail=%0d done21=%b data17=%h required 16/1/%h", navail, ob_done[21], ob_data[17], rep(8'd20));
        end
        dn_cycle = -1;
    endtask

    task automatic test_masked();
        dn_cycle = 20;
        run(10'd7, 16'd5, 16'h00F0, 24);
        for (int c = 1; c <= 24; c++) begin
            tests++;
            if (ob_mask[c] !== 16'h00F0) begin
                failed++;
                $display("FAIL masked_mask c=%0d got=%h required=00f0", c, ob_mask[c]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (ob_data[k+2] !== rep(exp_addr(7, 5, k)[7:0])) begin
                failed++;
                $display("FAIL masked_data k=%0d got=%h required=%h", k, ob_data[k+2], rep(exp_addr(7, 5, k)[7:0]));
            end
        end
        dn_cycle = -1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; done_norm = 1'b0;
        base_addr = '0; addr_stride = '0; mask_in = '0;
        test_reset();
        test_basic();
        test_stride_wrap();
        test_norm_disabled();
        test_start_while_busy();
        test_reset_mid();
        test_masked();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/norm_col_feeder.md
# norm_col_feeder

Transmit side of the normalization block's column-stream interface. On `start`, reads `DESIGN_SIZE` consecutive columns from a single-port block RAM (strided addresses, 1-cycle read latency) and drives them gap-free as `in_data_available`/`inp_data`/`validity_mask` into the norm block. It then waits for `done_norm` and reports completion to the top-level control FSM. It sits between the matmul result buffer and `norm`.

## Interface

Parameters:
- `DWIDTH`, 8, element width in bits
- `DESIGN_SIZE`, 16, columns per stream and elements per column
- `AWIDTH`, 10, RAM address width
- `ADDR_STRIDE_WIDTH`, 16, stride width
- `MASK_WIDTH`, 16, validity mask width

Ports:
- `clk` in 1, single clock; everything is sampled on the rising edge
- `reset` in 1, synchronous, active-high
- `start` in 1, one-cycle request; ignored unless the block is in IDLE
- `base_addr` in `AWIDTH`, address of column 0; sampled on an accepted `start`
- `addr_stride` in `ADDR_STRIDE_WIDTH`, address increment per column; sampled on an accepted `start`
- `mask_in` in `MASK_WIDTH`, element validity mask; sampled on an accepted `start`
- `ram_en` out 1, RAM read enable
- `ram_addr` out `AWIDTH`, RAM read address
- `ram_rdata` in `DESIGN_SIZE*DWIDTH`, RAM read data, valid 1 cycle after `ram_en`
- `in_data_available` out 1, column valid to norm
- `inp_data` out `DESIGN_SIZE*DWIDTH`, column data to norm
- `validity_mask` out `MASK_WIDTH`, held mask to norm
- `done_norm` in 1, completion from norm
- `busy` out 1, high from accepted `start` until the `done` cycle inclusive
- `done` out 1, one-cycle completion pulse

## Operation

- FSM states: IDLE, READ, LAST, WAIT_DONE, DONE.
- IDLE:
  - On `start`, latch `base_addr`, `addr_stride` and `mask_in`; clear column counter `k`; go to READ.
- READ:
  - Drive `ram_en`=1 and `ram_addr` = (base + k*stride) mod 2^`AWIDTH`.
  - The address is computed by an accumulator (add stride each cycle), not a multiplier. The upper stride bits beyond `AWIDTH` are discarded.
  - After issuing k=`DESIGN_SIZE`-1, go to LAST.
- LAST:
  - `ram_en`=0; final column is presented; go to WAIT_DONE.
- WAIT_DONE:
  - Hold outputs idle; on `done_norm`=1 go to DONE.
  - If `done_norm` is already 1 on entry (norm disabled), go to DONE the next cycle.
- DONE:
  - `done`=1 for one cycle; go to IDLE.
- Data path:
  - `in_data_available` is a 1-cycle delay of `ram_en`.
  - `inp_data` = `ram_rdata` when available, otherwise all-zero.
  - No gaps between columns are permitted.
- `validity_mask` holds the latched mask from the accepted `start` until the next accepted `start`. Reset value is 0.
- `start` while `busy` is dropped; there is no queuing.
- Reset mid-operation: next cycle the FSM is in IDLE, all outputs are 0, and the latched registers are cleared. An in-flight RAM read is discarded.

## Timing

- Reset values: `ram_en`, `ram_addr`, `in_data_available`, `inp_data`, `validity_mask`, `busy` and `done` are all 0.
- `start` sampled at edge T0:
  - `busy`=1 from T0+1.
  - `ram_en`=1 for T0+1 … T0+`DESIGN_SIZE`.
  - `in_data_available`=1 for T0+2 … T0+`DESIGN_SIZE`+1, exactly `DESIGN_SIZE` consecutive cycles, column k at T0+2+k.
- `done_norm` sampled high at edge Td: `done`=1 in cycle Td+1. `busy` drops at Td+2.
- Minimum start-to-start spacing is `DESIGN_SIZE`+4 cycles.
- `start` and `reset` in the same cycle: `reset` wins.

## Structure

- Shared package:
  - Constants `DWIDTH`, `DESIGN_SIZE`, `AWIDTH`, `ADDR_STRIDE_WIDTH`, `MASK_WIDTH`, `MEM_ACCESS_LATENCY`=1.
  - FSM state encoding.
- One sub-module, `norm_addr_gen`: a strided address accumulator plus column counter with load, step and last-flag outputs.

## Test plan

- **Basic stream:** reset, then `start` with base=0, stride=1, mask=16'hFFFF, RAM[a]=a replicated per byte, `done_norm` returned at T0+20.
  - Addresses 0..15 on T0+1..T0+16.
  - `in_data_available` high for T0+2..T0+17 with column k bytes = k.
  - `done` at T0+21.
- **Stride wrap:** base=1020, stride=3.
  - Addresses 1020, 1023, 2, 5, …, 41.
  - Data matches the RAM model.
- **Norm disabled:** `done_norm` tied to 1.
  - `done` pulses the cycle after LAST+1, at T0+19.
  - `busy` is low at T0+20.
- **Start while busy:** second `start` at T0+5 with base=100.
  - It is ignored: the address sequence and mask are unchanged, and only one `done` occurs.
- **Reset mid-stream:** `reset` at T0+8.
  - At T0+9 all outputs are 0 and the FSM is in IDLE.
  - A fresh `start` then completes a full 16-column stream.
- **Masked lanes:** mask=16'h00F0 with norm in the loop.
  - `validity_mask`=16'h00F0 throughout.
  - Norm outputs pass lanes 0-3 and 8-15 through unchanged.
